sw_serial_reader: RTL and testbench
===================================

# sw_serial_reader

Serial-in/parallel-out input controller for the board's 74HC165-style switch/button shift-register chain. It is the read-side counterpart of the LED serial output path. It periodically parallel-loads the external chain, clocks the bits in MSB first, and latches a WIDTH-bit snapshot into a CPU-readable register. A sticky change flag in that register is cleared by a CPU write.

## Interface
Parameters:
- CLK_DIV, 8, system cycles per sr_clk half-period and per load pulse; legal range 4..255.
- WIDTH, 16, number of bits in the external chain; legal range 1..31.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; while high, scans repeat back-to-back.
- we  in  4  byte write enables from the bus.
- wdata  in  32  bus write data.
- rdata  out  32  {chg, (31-WIDTH) zeros, data[WIDTH-1:0]}.
- sr_dat  in  1  serial data from the chain (asynchronous).
- sr_clk  out  1  shift clock to the chain.
- sr_load_n  out  1  parallel-load strobe, active low.
- busy  out  1  high while a scan is in progress (any state except IDLE).
- finish  out  1  one-cycle pulse when data is updated.

## Operation
- sr_dat passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Counters:
  - div_cnt counts 0..CLK_DIV-1 within each phase.
  - bit_cnt counts 0..WIDTH-1.
  - shreg is a WIDTH-bit shift register.
- States:
  - **IDLE**: sr_clk=0, sr_load_n=1.
    - If en=1: go to LOAD with div_cnt=0.
    - Otherwise stay in IDLE.
  - **LOAD**: sr_load_n=0 for CLK_DIV cycles.
    - Then go to SHIFT_LO with bit_cnt=0 and div_cnt=0.
  - **SHIFT_LO**: sr_clk=0 for CLK_DIV cycles.
    - On the last cycle (div_cnt=CLK_DIV-1): shreg <= {shreg[WIDTH-2:0], sync_dat}.
    - Then go to SHIFT_HI.
  - **SHIFT_HI**: sr_clk=1 for CLK_DIV cycles; the chain shifts on the rising edge.
    - At the end, if bit_cnt=WIDTH-1, go to DONE.
    - Otherwise increment bit_cnt and go to SHIFT_LO.
  - **DONE**: one cycle.
    - data <= shreg and finish=1.
    - If shreg != data, set chg.
    - Next state is IDLE.
- Bit ordering:
  - The first bit sampled is the chain's first output (Q7 of the first device).
  - That bit ends up in data[WIDTH-1]; the last bit sampled ends up in data[0].
- Bus writes:
  - When we[3]=1 and wdata[31]=1, chg is cleared.
  - All other writes are ignored; data is read-only.
  - If a clear write and a DONE-set of chg occur in the same cycle, the set wins.
- en behaviour:
  - Deasserting en mid-scan does not abort the scan; it completes and then stays in IDLE.
  - en is sampled only in IDLE.
- Reset:
  - Applies in any state, including mid-scan; the scan is abandoned.
  - Returns to IDLE.
  - Values after reset: data=0, shreg=0, chg=0, counters=0, sr_clk=0, sr_load_n=1, busy=0, finish=0, synchronizer flops=0.
- All outputs are registered; no combinational path from sr_dat or we to any output.

## Timing
- Scan length, from entering LOAD to the finish pulse inclusive: CLK_DIV + 2·WIDTH·CLK_DIV + 1 cycles. With defaults this is 265.
- Back-to-back scans with en held high: LOAD starts every CLK_DIV·(2·WIDTH+1) + 2 cycles. With defaults this is 266 (includes one IDLE cycle).
- A bit is sampled CLK_DIV-1 cycles after sr_clk falls, or after load ends for bit 0.
  - Because of the 2-flop synchronizer, the sampled value reflects sr_dat as it was 2 cycles before the sample edge.
  - CLK_DIV ≥ 4 guarantees this lands inside the stable window.
- rdata reflects new data and chg on the cycle after the finish pulse.
- First LOAD after rst falls with en=1: sr_load_n goes low 1 cycle after IDLE samples en.

## Test plan
- **Basic scan**: chain model preloaded with 16'hA5C3, en pulsed high for 1 cycle → single scan; sr_load_n low for 8 cycles; 16 sr_clk pulses of 8 high/8 low cycles each; finish is high 265 cycles after LOAD entry; rdata=32'h8000A5C3; busy returns low.
- **Change flag and clear**: second scan with the same 16'hA5C3 → chg stays 1. Write we=4'b1000, wdata=32'h80000000 → rdata=32'h0000A5C3. Third scan with 16'h0001 → rdata=32'h80000001.
- **Clear/set collision**: issue the chg-clear write in the exact DONE cycle of a scan whose value changes (16'hFFFF) → chg=1, rdata=32'h8000FFFF.
- **Continuous mode and en drop**: hold en=1 for 3 scans → LOAD entries are 266 cycles apart. Drop en in mid-SHIFT of the 3rd scan → that scan completes with finish, then busy=0 and sr_load_n stays 1.
- **Reset mid-scan**: assert rst during SHIFT_HI of bit 7 → next cycle sr_clk=0, sr_load_n=1, busy=0, rdata=0. Release rst with en=1 → a full fresh scan returns the chain value correctly.
- **Parameter corner**: WIDTH=1, CLK_DIV=4, chain bit=1 → scan is 4+8+1=13 cycles; rdata=32'h80000001.

Source files
------------

// File: rtl/sw_serial_reader.sv
// -----------------------------------------------------------------------------
// sw_serial_reader
//
// Read-side controller for the board's 74HC165-style switch/button chain.
// Each scan parallel-loads the external chain, clocks WIDTH bits in MSB first
// and latches the snapshot into a CPU-readable register. A sticky change flag
// (bit 31 of rdata) is set whenever a scan returns a value different from the
// previous snapshot, and is cleared by a bus write of 1 to bit 31 (byte lane 3).
//
// Parameters
//   CLK_DIV   system cycles per sr_clk half-period and per load pulse (4..255)
//   WIDTH     number of bits in the external chain (1..31)
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   en         scan enable; scans repeat back-to-back while high
//   we         byte write enables from the bus
//   wdata      bus write data (only bit 31 with we[3] has an effect)
//   rdata      {chg, zeros, data[WIDTH-1:0]}
//   sr_dat     serial data from the chain (asynchronous to clk)
//   sr_clk     shift clock to the chain
//   sr_load_n  parallel-load strobe to the chain, active low
//   busy       high while a scan is in progress
//   finish     one-cycle pulse in the cycle the snapshot is updated
// -----------------------------------------------------------------------------
module sw_serial_reader #(
    parameter int CLK_DIV = 8,
    parameter int WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        sr_dat,
    output logic        sr_clk,
    output logic        sr_load_n,
    output logic        busy,
    output logic        finish
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         div_cnt_q, div_cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               chg_q, chg_d;
    logic               sync1_q, sync2_q;
    logic               sr_clk_q, sr_load_n_q, busy_q, finish_q;
    logic [WIDTH-1:0]   shreg_shifted;

    // Shift left, new bit enters at the LSB. Built bit by bit so that the
    // single-bit chain needs no special case.
    assign shreg_shifted[0] = sync2_q;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shreg_shifted[gi] = shreg_q[gi-1];
        end
    endgenerate

    wire div_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        chg_d     = chg_q;

        // Clear first so a DONE-cycle set below overrides a same-cycle clear.
        if (we[3] && wdata[31]) begin
            chg_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = S_LOAD;
                    div_cnt_d = 8'd0;
                end
            end
            S_LOAD: begin
                if (div_last) begin
                    state_d   = S_SHIFT_LO;
                    bit_cnt_d = 5'd0;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_SHIFT_LO: begin
                // Sample at the very end of the low phase: the chain output
                // has been settled for the whole phase by then.
                if (div_last) begin
                    shreg_d   = shreg_shifted;
                    state_d   = S_SHIFT_HI;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = S_SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                data_d = shreg_q;
                if (shreg_q != data_q) begin
                    chg_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            chg_q       <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sr_clk_q    <= 1'b0;
            sr_load_n_q <= 1'b1;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            chg_q       <= chg_d;
            sync1_q     <= sr_dat;
            sync2_q     <= sync1_q;
            // Pin outputs are decoded from the next state so that each flop
            // is exactly aligned with the state it belongs to.
            sr_clk_q    <= (state_d == S_SHIFT_HI);
            sr_load_n_q <= (state_d != S_LOAD);
            busy_q      <= (state_d != S_IDLE);
            finish_q    <= (state_d == S_DONE);
        end
    end

    assign rdata     = {chg_q, 31'(data_q)};
    assign sr_clk    = sr_clk_q;
    assign sr_load_n = sr_load_n_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_sw_serial_reader.sv
// -----------------------------------------------------------------------------
// tb_sw_serial_reader
//
// Directed bench for sw_serial_reader: a default-parameter instance driven by a
// 16-bit 74HC165-style chain model, plus a WIDTH=1 / CLK_DIV=4 instance with a
// one-bit chain model.
// -----------------------------------------------------------------------------
module tb_sw_serial_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic [3:0]  we;
    logic [31:0] wdata, rdata;
    logic        sr_dat, sr_clk, sr_load_n, busy, finish;

    logic        en1;
    logic [3:0]  we1    = 4'd0;
    logic [31:0] wdata1 = 32'd0;
    logic [31:0] rdata1;
    logic        sr_dat1, sr_clk1, sr_load_n1, busy1, finish1;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    sw_serial_reader #(.CLK_DIV(8), .WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .wdata(wdata), .rdata(rdata),
        .sr_dat(sr_dat), .sr_clk(sr_clk), .sr_load_n(sr_load_n),
        .busy(busy), .finish(finish)
    );

    sw_serial_reader #(.CLK_DIV(4), .WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .we(we1), .wdata(wdata1), .rdata(rdata1),
        .sr_dat(sr_dat1), .sr_clk(sr_clk1), .sr_load_n(sr_load_n1),
        .busy(busy1), .finish(finish1)
    );

    // 16-bit chain: parallel load while load_n low, shift on sr_clk rise,
    // serial output is the MSB.
    logic [15:0] chain_val = 16'h0000;
    logic [15:0] chain_q   = 16'h0000;
    logic        sr_clk_prev = 1'b0;
    always @(posedge clk) begin
        sr_clk_prev <= sr_clk;
        if (!sr_load_n)
            chain_q <= chain_val;
        else if (sr_clk && !sr_clk_prev)
            chain_q <= {chain_q[14:0], 1'b0};
    end
    assign sr_dat = chain_q[15];

    logic chain1_val = 1'b0;
    logic chain1_q   = 1'b0;
    logic sr_clk1_prev = 1'b0;
    always @(posedge clk) begin
        sr_clk1_prev <= sr_clk1;
        if (!sr_load_n1)
            chain1_q <= chain1_val;
        else if (sr_clk1 && !sr_clk1_prev)
            chain1_q <= 1'b0;
    end
    assign sr_dat1 = chain1_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first LOAD cycle (or anywhere mid-scan); returns in the
    // cycle where finish is high, optionally driving a chg-clear write there.
    task automatic wait_scan(input bit clr_at_done, output int len,
                             output int loads, output int pulses, output int his);
        logic prev_clk;
        len = -1; loads = 0; pulses = 0; his = 0;
        prev_clk = sr_clk;
        for (int n = 1; n <= 4000; n++) begin
            if (!sr_load_n) loads++;
            if (sr_clk) his++;
            if (sr_clk && !prev_clk) pulses++;
            prev_clk = sr_clk;
            if (finish) begin
                len = n;
                if (clr_at_done) begin
                    we    = 4'b1000;
                    wdata = 32'h8000_0000;
                end
                return;
            end
            tick();
        end
        check("scan_timeout", {31'd0, finish}, 32'd1);
    endtask

    task automatic wait_load(output int cyc);
        cyc = -1;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (!sr_load_n) begin
                cyc = cycle_cnt;
                return;
            end
        end
        check("load_timeout", {31'd0, sr_load_n}, 32'd0);
    endtask

    task automatic single_scan(input logic [15:0] val, input bit clr_at_done,
                               output int len, output int loads,
                               output int pulses, output int his);
        chain_val = val;
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_scan(clr_at_done, len, loads, pulses, his);
    endtask

    initial begin
        int len, loads, pulses, his;
        int c0, c1, c2, lows;

        rst = 1'b1; en = 1'b0; en1 = 1'b0; we = 4'd0; wdata = 32'd0;
        repeat (3) tick();

        // Reset state
        check("rst_rdata",     rdata,  32'h0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_finish",    {31'd0, finish},    32'd0);
        check("rst_sr_clk",    {31'd0, sr_clk},    32'd0);
        check("rst_sr_load_n", {31'd0, sr_load_n}, 32'd1);
        check("rst_rdata1",    rdata1, 32'h0);
        rst = 1'b0;
        tick();

        // Basic scan
        single_scan(16'hA5C3, 1'b0, len, loads, pulses, his);
        check("basic_len",    len,    32'd265);
        check("basic_loads",  loads,  32'd8);
        check("basic_pulses", pulses, 32'd16);
        check("basic_hi",     his,    32'd128);
        tick();
        $display("scan 1: rdata=%h", rdata);
        check("basic_rdata", rdata, 32'h8000_A5C3);
        check("basic_busy",  {31'd0, busy}, 32'd0);

        // Same value again: chg stays set
        single_scan(16'hA5C3, 1'b0, len, loads, pulses, his);
        tick();
        $display("scan 2: rdata=%h", rdata);
        check("same_rdata", rdata, 32'h8000_A5C3);

        // Write without we[3] is ignored
        we = 4'b0111; wdata = 32'hFFFF_FFFF;
        tick();
        we = 4'd0; wdata = 32'd0;
        $display("ignored write: rdata=%h", rdata);
        check("ignored_write", rdata, 32'h8000_A5C3);

        // Clear chg
        we = 4'b1000; wdata = 32'h8000_0000;
        tick();
        we = 4'd0; wdata = 32'd0;
        $display("clear write: rdata=%h", rdata);
        check("clear_rdata", rdata, 32'h0000_A5C3);

        // New value sets chg
        single_scan(16'h0001, 1'b0, len, loads, pulses, his);
        tick();
        $display("scan 3: rdata=%h", rdata);
        check("third_rdata", rdata, 32'h8000_0001);

        // Clear, then collide a clear write with the DONE-cycle set
        we = 4'b1000; wdata = 32'h8000_0000;
        tick();
        we = 4'd0; wdata = 32'd0;
        check("preclr_rdata", rdata, 32'h0000_0001);
        single_scan(16'hFFFF, 1'b1, len, loads, pulses, his);
        tick();
        we = 4'd0; wdata = 32'd0;
        $display("collision: rdata=%h", rdata);
        check("collision_rdata", rdata, 32'h8000_FFFF);

        // Continuous mode
        chain_val = 16'h1234;
        en = 1'b1;
        tick();
        c0 = cycle_cnt;
        wait_scan(1'b0, len, loads, pulses, his);
        wait_load(c1);
        $display("continuous: load period %0d", c1 - c0);
        check("cont_period1", c1 - c0, 32'd266);
        wait_scan(1'b0, len, loads, pulses, his);
        wait_load(c2);
        $display("continuous: load period %0d", c2 - c1);
        check("cont_period2", c2 - c1, 32'd266);
        repeat (100) tick();
        en = 1'b0;
        wait_scan(1'b0, len, loads, pulses, his);
        check("endrop_finish", {31'd0, finish}, 32'd1);
        tick();
        check("endrop_busy", {31'd0, busy}, 32'd0);
        lows = 0;
        repeat (20) begin
            tick();
            if (!sr_load_n || busy) lows++;
        end
        $display("en drop: idle violations %0d", lows);
        check("endrop_idle", lows, 32'd0);

        // Reset mid-scan during SHIFT_HI of bit 7
        chain_val = 16'h3C5A;
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (130) tick();
        check("midscan_hi", {31'd0, sr_clk}, 32'd1);
        rst = 1'b1;
        tick();
        $display("reset mid-scan: rdata=%h busy=%b", rdata, busy);
        check("midrst_sr_clk",    {31'd0, sr_clk},    32'd0);
        check("midrst_sr_load_n", {31'd0, sr_load_n}, 32'd1);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        check("midrst_rdata",     rdata,              32'h0);
        en = 1'b1;
        rst = 1'b0;
        tick();
        check("postrst_load", {31'd0, sr_load_n}, 32'd0);
        en = 1'b0;
        wait_scan(1'b0, len, loads, pulses, his);
        check("postrst_len", len, 32'd265);
        tick();
        $display("post-reset scan: rdata=%h", rdata);
        check("postrst_rdata", rdata, 32'h8000_3C5A);

        // Parameter corner: WIDTH=1, CLK_DIV=4
        chain1_val = 1'b1;
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        len = -1;
        for (int n = 1; n <= 200; n++) begin
            if (finish1) begin
                len = n;
                break;
            end
            tick();
        end
        $display("corner scan: length %0d", len);
        check("corner_len", len, 32'd13);
        tick();
        $display("corner scan: rdata=%h", rdata1);
        check("corner_rdata", rdata1, 32'h8000_0001);
        check("corner_busy",  {31'd0, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
